// File: rtl/uart_prog_loader_pkg.sv
// Shared types and widths for the UART program loader and its receiver.
package uart_prog_loader_pkg;

    localparam int UPG_ADR_W = 14;
    localparam int UPG_DAT_W = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
        WRITE  = 3'd4,
        DONE   = 3'd5
    } loader_state_e;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/uart_prog_loader_rx.sv
// 8N1 UART receiver: two-flop synchronizer, start-bit glitch rejection, bit-centre sampling.
module uart_rx
    import uart_prog_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_ferr
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    logic [1:0]    sync_q;
    logic          prev_q;
    logic          rx_s;
    rx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    data_q, data_d;

    assign rx_s    = sync_q[1];
    assign rx_data = data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b11;
            prev_q  <= 1'b1;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            data_q  <= '0;
        end else begin
            sync_q  <= {sync_q[0], rx};
            prev_q  <= rx_s;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        data_d   = data_q;
        rx_valid = 1'b0;
        rx_ferr  = 1'b0;
        unique case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                if (prev_q && !rx_s) state_d = RX_START;
            end
            RX_START: begin
                // A start bit that is high again at mid-bit was a glitch.
                if (cnt_q == HALF) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_s ? RX_IDLE : RX_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL) begin
                    cnt_d  = '0;
                    data_d = {rx_s, data_q[7:1]};
                    bit_d  = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = RX_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL) begin
                    rx_valid = 1'b1;
                    rx_ferr  = !rx_s;
                    cnt_d    = '0;
                    state_d  = RX_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/uart_prog_loader.sv
// Serial bootloader: receives a length-prefixed word image over UART and writes it into the instruction ROM.
module uart_prog_loader
    import uart_prog_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int MAX_WORDS    = 16384
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    input  logic                 start,
    output logic                 upg_clk_o,
    output logic                 upg_rst_o,
    output logic                 upg_wen_o,
    output logic [UPG_ADR_W-1:0] upg_adr_o,
    output logic [UPG_DAT_W-1:0] upg_dat_o,
    output logic                 upg_done_o,
    output logic                 busy,
    output logic                 frame_err,
    output loader_state_e        dbg_state_o
);
    localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

    logic [7:0]           rx_data;
    logic                 rx_valid;
    logic                 rx_ferr;
    loader_state_e        state_q, state_d;
    logic [UPG_ADR_W-1:0] adr_q, adr_d;
    logic [UPG_DAT_W-1:0] dat_q, dat_d;
    logic [1:0]           k_q, k_d;
    logic [15:0]          len_q, len_d;
    logic                 ferr_q, ferr_d;
    logic [15:0]          n_raw;

    uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx       (rx),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ferr  (rx_ferr)
    );

    assign upg_clk_o   = clk;
    assign upg_rst_o   = (state_q == IDLE);
    assign upg_wen_o   = (state_q == WRITE);
    assign upg_done_o  = (state_q == DONE);
    assign busy        = (state_q != IDLE) && (state_q != DONE);
    assign upg_adr_o   = adr_q;
    assign upg_dat_o   = dat_q;
    assign frame_err   = ferr_q;
    assign dbg_state_o = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            adr_q   <= '0;
            dat_q   <= '0;
            k_q     <= '0;
            len_q   <= '0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            k_q     <= k_d;
            len_q   <= len_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        k_d     = k_q;
        len_d   = len_q;
        ferr_d  = ferr_q;
        n_raw   = {rx_data, len_q[7:0]};
        unique case (state_q)
            IDLE, DONE: begin
                // Bytes arriving here are dropped; only start opens a session.
                if (start) begin
                    state_d = LEN_LO;
                    adr_d   = '0;
                    k_d     = '0;
                    ferr_d  = 1'b0;
                end
            end
            LEN_LO: if (rx_valid) begin
                len_d   = {8'h00, rx_data};
                state_d = LEN_HI;
            end
            LEN_HI: if (rx_valid) begin
                len_d   = (n_raw > MAX_N) ? MAX_N : n_raw;
                state_d = (n_raw == 16'd0) ? DONE : DATA;
            end
            DATA: if (rx_valid) begin
                dat_d[{k_q, 3'b000} +: 8] = rx_data;
                k_d = k_q + 2'd1;
                if (k_q == 2'd3) state_d = WRITE;
            end
            WRITE: begin
                adr_d   = adr_q + 1'b1;
                k_d     = '0;
                state_d = ({2'b00, adr_q} == len_q - 16'd1) ? DONE : DATA;
            end
            default: state_d = IDLE;
        endcase
        // Framing errors only count for bytes the session actually consumes.
        if (rx_valid && rx_ferr && (state_q inside {LEN_LO, LEN_HI, DATA})) ferr_d = 1'b1;
    end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader: byte-table sessions plus hand-written corner sequences.
module tb_uart_prog_loader;
    import uart_prog_loader_pkg::*;

    localparam int CPB = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          rx = 1'b1;
    logic          start = 1'b0;
    logic          upg_clk_o, upg_rst_o, upg_wen_o, upg_done_o, busy, frame_err;
    logic [13:0]   upg_adr_o;
    logic [31:0]   upg_dat_o;
    loader_state_e dbg_state;

    int vec_cnt = 0;
    int err_cnt = 0;

    // {last word of session, address, data}
    logic [46:0] exp_q[$];
    logic        chk_next = 1'b0;
    logic        next_last = 1'b0;

    typedef struct {
        logic       do_start;
        logic [7:0] b;
        logic       bad;
        logic       exp_busy;
        logic       exp_done;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs[$];

    uart_prog_loader #(.CLKS_PER_BIT(CPB), .MAX_WORDS(16384)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx          (rx),
        .start       (start),
        .upg_clk_o   (upg_clk_o),
        .upg_rst_o   (upg_rst_o),
        .upg_wen_o   (upg_wen_o),
        .upg_adr_o   (upg_adr_o),
        .upg_dat_o   (upg_dat_o),
        .upg_done_o  (upg_done_o),
        .busy        (busy),
        .frame_err   (frame_err),
        .dbg_state_o (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Write monitor: every strobe must match the next expected write, last only one cycle,
    // and done must follow exactly when the write was the session's last.
    always @(negedge clk) begin
        if (chk_next) begin
            check("wen_one_cycle", {31'd0, upg_wen_o}, 32'd0);
            check("done_after_wen", {31'd0, upg_done_o}, {31'd0, next_last});
            chk_next = 1'b0;
        end
        if (upg_wen_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected_wen", 32'd1, 32'd0);
            end else begin
                logic [46:0] e;
                e = exp_q.pop_front();
                check("wen_adr", {18'd0, upg_adr_o}, {18'd0, e[45:32]});
                check("wen_dat", upg_dat_o, e[31:0]);
                next_last = e[46];
                chk_next  = 1'b1;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad);
        tick(1);
        rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            tick(CPB);
        end
        rx = ~bad;
        tick(CPB);
        rx = 1'b1;
        tick(2 * CPB);
    endtask

    task automatic pulse_start();
        tick(1);
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic add(input logic s, input logic [7:0] b, input logic bad,
                       input logic eb, input logic ed, input logic ef);
        vec_t v;
        v.do_start = s; v.b = b; v.bad = bad;
        v.exp_busy = eb; v.exp_done = ed; v.exp_ferr = ef;
        vecs.push_back(v);
    endtask

    task automatic send_bytes(input logic [7:0] bs[$]);
        foreach (bs[i]) send_byte(bs[i], 1'b0);
    endtask

    initial begin
        // Expected writes in session order across the whole run.
        exp_q.push_back({1'b0, 14'd0, 32'h12345678});
        exp_q.push_back({1'b1, 14'd1, 32'hDEADBEEF});
        exp_q.push_back({1'b1, 14'd0, 32'h44332211});
        exp_q.push_back({1'b1, 14'd0, 32'hDDCCBBAA});
        exp_q.push_back({1'b0, 14'd0, 32'h03020100});
        exp_q.push_back({1'b0, 14'd1, 32'h13121110});
        exp_q.push_back({1'b1, 14'd2, 32'h23222120});

        // Two-word image
        add(1, 8'h02, 0, 1, 0, 0); add(0, 8'h00, 0, 1, 0, 0);
        add(0, 8'h78, 0, 1, 0, 0); add(0, 8'h56, 0, 1, 0, 0);
        add(0, 8'h34, 0, 1, 0, 0); add(0, 8'h12, 0, 1, 0, 0);
        add(0, 8'hEF, 0, 1, 0, 0); add(0, 8'hBE, 0, 1, 0, 0);
        add(0, 8'hAD, 0, 1, 0, 0); add(0, 8'hDE, 0, 0, 1, 0);
        // Empty image
        add(1, 8'h00, 0, 1, 0, 0); add(0, 8'h00, 0, 0, 1, 0);
        // One word with a bad stop bit on the second data byte
        add(1, 8'h01, 0, 1, 0, 0); add(0, 8'h00, 0, 1, 0, 0);
        add(0, 8'h11, 0, 1, 0, 0); add(0, 8'h22, 1, 1, 0, 1);
        add(0, 8'h33, 0, 1, 0, 1); add(0, 8'h44, 0, 0, 1, 1);
        // New session clears frame_err; then a stray byte in DONE is dropped
        add(1, 8'h00, 0, 1, 0, 0); add(0, 8'h00, 0, 0, 1, 0);
        add(0, 8'h55, 0, 0, 1, 0);

        // Reset and idle
        tick(3);
        check("rst_upg_rst", {31'd0, upg_rst_o}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, upg_done_o}, 32'd0);
        check("rst_wen", {31'd0, upg_wen_o}, 32'd0);
        check("rst_adr", {18'd0, upg_adr_o}, 32'd0);
        check("rst_dat", upg_dat_o, 32'd0);
        check("rst_ferr", {31'd0, frame_err}, 32'd0);
        rst_n = 1'b1;
        tick(50);
        check("idle_upg_rst", {31'd0, upg_rst_o}, 32'd1);
        check("idle_done", {31'd0, upg_done_o}, 32'd0);

        foreach (vecs[i]) begin
            if (vecs[i].do_start) begin
                pulse_start();
                check("start_upg_rst", {31'd0, upg_rst_o}, 32'd0);
            end
            send_byte(vecs[i].b, vecs[i].bad);
            check($sformatf("v%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].exp_busy});
            check($sformatf("v%0d_done", i), {31'd0, upg_done_o}, {31'd0, vecs[i].exp_done});
            check($sformatf("v%0d_ferr", i), {31'd0, frame_err}, {31'd0, vecs[i].exp_ferr});
        end

        // Start during DATA is ignored; a 1-cycle rx glitch is not a byte
        pulse_start();
        send_bytes('{8'h01, 8'h00, 8'hAA, 8'hBB});
        pulse_start();
        check("s5_state", {29'd0, dbg_state}, {29'd0, DATA});
        check("s5_adr", {18'd0, upg_adr_o}, 32'd0);
        check("s5_busy", {31'd0, busy}, 32'd1);
        rx = 1'b0;
        tick(1);
        rx = 1'b1;
        tick(60);
        check("s5_glitch_state", {29'd0, dbg_state}, {29'd0, DATA});
        send_bytes('{8'hCC, 8'hDD});
        check("s5_done", {31'd0, upg_done_o}, 32'd1);

        // Reset mid-session, then reprogram the full image from address 0
        pulse_start();
        send_bytes('{8'h03, 8'h00, 8'hF0, 8'hF1, 8'hF2});
        rst_n = 1'b0;
        tick(2);
        check("s6_upg_rst", {31'd0, upg_rst_o}, 32'd1);
        check("s6_busy", {31'd0, busy}, 32'd0);
        check("s6_adr", {18'd0, upg_adr_o}, 32'd0);
        check("s6_done", {31'd0, upg_done_o}, 32'd0);
        rst_n = 1'b1;
        tick(10);
        pulse_start();
        send_bytes('{8'h03, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03,
                     8'h10, 8'h11, 8'h12, 8'h13, 8'h20, 8'h21, 8'h22, 8'h23});
        check("s6_final_done", {31'd0, upg_done_o}, 32'd1);
        check("s6_final_adr", {18'd0, upg_adr_o}, 32'd3);

        tick(5);
        check("all_writes_seen", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/uart_prog_loader.md
# uart_prog_loader

Serial bootloader that receives a program image over a UART RX line and writes it word-by-word into the instruction ROM through the `upg_*` programming port. Drives `upg_rst_o`, `upg_wen_o`, `upg_adr_o`, `upg_dat_o` and `upg_done_o`, which feed the `upg_*_i` inputs of the PC/instruction-fetch block. The ROM uses the upgrade port while `upg_rst_o=0 && upg_done_o=0`; otherwise the CPU fetches normally.

## Interface
- `CLKS_PER_BIT`, default 868: clk cycles per UART bit (100 MHz / 115200 baud); must be ≥ 4.
- `MAX_WORDS`, default 16384: ROM depth in words; must match the 14-bit address space.

- `clk`  in  1  loader clock; also forwarded as `upg_clk_o`.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `rx`  in  1  UART serial input, 8N1, idle high; asynchronous to `clk`.
- `start`  in  1  one-cycle request to begin a programming session.
- `upg_clk_o`  out  1  equals `clk`.
- `upg_rst_o`  out  1  1 = not programming (CPU owns the ROM).
- `upg_wen_o`  out  1  one-cycle ROM write strobe.
- `upg_adr_o`  out  14  word address of the current write.
- `upg_dat_o`  out  32  write data.
- `upg_done_o`  out  1  session completed.
- `busy`  out  1  session in progress.
- `frame_err`  out  1  sticky; set on a bad stop bit, cleared by `start`.

## Operation
- Image format: 2-byte word count N (low byte first), then N words of 4 bytes each, low byte first.
- N = 0 finishes the session immediately after the count. N > MAX_WORDS saturates to MAX_WORDS.
- States:
  - IDLE: `upg_rst_o=1`, `busy=0`.
  - LEN_LO: on byte, load N[7:0] → LEN_HI.
  - LEN_HI: on byte, load N[15:8] → DATA, or → DONE if N = 0.
  - DATA: shift the byte into `upg_dat_o[8*k+:8]` and increment k. On the 4th byte → WRITE.
  - WRITE: assert `upg_wen_o` for one cycle, then increment the address. → DONE if the word index equals N−1, else → DATA with k = 0.
  - DONE: `upg_done_o=1`, `upg_rst_o=0`.
- `start` in IDLE or DONE:
  - clears address, k, `frame_err` and `upg_done_o`;
  - drives `upg_rst_o=0`, `busy=1`;
  - moves to LEN_LO.
- `start` in any other state is ignored.
- A byte with a framing error:
  - sets `frame_err`;
  - is still consumed as data, so the byte count stays in step with the host.
- Bytes received in IDLE or DONE are discarded.
- `upg_adr_o` wraps modulo 2^14. Wrapping is only reachable at MAX_WORDS, where the session ends first.

## Timing
- Reset values:
  - `upg_rst_o=1`
  - `upg_wen_o=0`, `upg_done_o=0`, `busy=0`, `frame_err=0`
  - `upg_adr_o=0`, `upg_dat_o=0`
  - state IDLE; RX deserializer idle.
- `rx` is synchronized through 2 flops before use.
- Start bit:
  - detected on a falling edge;
  - re-checked at CLKS_PER_BIT/2; if high, it is a glitch and RX returns to idle.
- Data bits and the stop bit are sampled at bit centres.
- `rx_valid` pulses for 1 cycle at the stop-bit sample.
- The FSM consumes `rx_valid` in that same cycle.
- `upg_wen_o` is high exactly 1 cycle, the cycle after the 4th byte's `rx_valid`.
- `upg_adr_o` and `upg_dat_o` are stable throughout the `wen` cycle.
- `upg_done_o` rises the cycle after the last `wen`. It holds until `start` or reset.
- `rst_n` low mid-session aborts immediately to reset values, so the CPU regains the ROM. The partial image remains in the ROM.

## Structure
- Shared package:
  - state encoding `IDLE/LEN_LO/LEN_HI/DATA/WRITE/DONE`;
  - `UPG_ADR_W=14`, `UPG_DAT_W=32`.
- One sub-module: `uart_rx`.
  - Parameter `CLKS_PER_BIT`.
  - Ports: `clk`, `rst_n`, `rx` → `rx_data[7:0]`, `rx_valid`, `rx_ferr`.
  - Contains the synchronizer and the bit-centre counter.
- The top level holds the loader FSM, word assembler, address counter and length register.

## Test plan
All scenarios use `CLKS_PER_BIT=4`.
1. Reset, then idle: `upg_rst_o=1`, `upg_done_o=0`, `wen` never pulses.
2. `start`, send `02 00 78 56 34 12 EF BE AD DE`:
   - `wen` at adr 0 with 0x12345678;
   - `wen` at adr 1 with 0xDEADBEEF;
   - `upg_done_o=1` the next cycle;
   - exactly 2 `wen` pulses.
3. `start`, send `00 00`: `upg_done_o=1` after the 2nd byte, no `wen`.
4. Send a byte whose stop bit is 0 during DATA:
   - `frame_err=1`;
   - the word is still written after 4 bytes;
   - the next `start` clears `frame_err`.
5. `start` pulse during DATA is ignored, address unchanged. A 1-cycle low glitch on idle `rx` produces no byte.
6. `rst_n` low after 5 bytes of a 3-word image:
   - `upg_rst_o=1`, `busy=0`, adr 0;
   - a new `start` plus full image programs from adr 0.
